fma_dot_sequencer: RTL
======================

Name: fma_dot_sequencer

Overview:
Sequencer that drives one fused multiply-add unit through a full dot product. It fetches A and B operands from two synchronous-read operand memories and pulses the FMA enable once per element. On the first element it selects the seed. It returns the final sum through a valid/ready result port. It sits between the matrix-processor command logic and the FMA datapath, so one FMA can serve row×column jobs of runtime length.

Parameters:
WIDTH, 32, operand/accumulator width (matches FMA WIDTH)
ADDR_W, 8, operand memory address width; also width of len and stride

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  job request, accepted only in IDLE
base_a  in  ADDR_W  first A address
base_b  in  ADDR_W  first B address
stride_b  in  ADDR_W  B address increment per element (1 = row, N = column)
len  in  ADDR_W  element count, 0 allowed
seed  in  WIDTH  initial accumulator value
abort  in  1  cancel current job, no result
busy  out  1  high in RUN or DONE
mem_a_addr  out  ADDR_W  A read address
mem_b_addr  out  ADDR_W  B read address
mem_rd  out  1  read strobe, data valid on the next cycle
mem_a_data  in  WIDTH  A read data (1-cycle latency)
mem_b_data  in  WIDTH  B read data (1-cycle latency)
fma_a  out  WIDTH  to FMA a
fma_b  out  WIDTH  to FMA b
fma_seed  out  WIDTH  to FMA seed
fma_update_acc  out  1  to FMA updateAccumulator
fma_en  out  1  to FMA en
fma_acc  in  WIDTH  FMA combinational accumulator output
res_valid  out  1  result available
res_data  out  WIDTH  dot product result
res_ready  in  1  consumer accepts result

Behaviour:
- Reset: all outputs and registers go to 0 and the state goes to IDLE. The reset applies mid-job too; an in-flight job is discarded.
- FMA contract: fma_acc = (fma_update_acc ? fma_seed : acc) + fma_a*fma_b, truncated to WIDTH bits. The FMA registers acc when fma_en is high.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches base_a, base_b, stride_b, len and seed.
  - If len≠0, go to RUN.
  - If len=0, go to DONE with res_data=seed. No memory reads and no FMA enables occur for len=0.
- RUN, issue stage:
  - The issue index i runs 0..len-1, one per cycle.
  - mem_rd=1, mem_a_addr=base_a+i, mem_b_addr=base_b+i*stride_b. The B address is computed incrementally by adding stride_b each cycle.
  - Both address computations are modulo 2^ADDR_W; wrap is silent.
- RUN, execute stage (one cycle behind issue):
  - fma_a=mem_a_data, fma_b=mem_b_data, fma_en=1.
  - fma_update_acc=1 only for element 0. fma_seed holds the latched seed throughout the job.
- Leaving RUN: in the execute cycle of element len-1, capture res_data <= fma_acc and go to DONE.
- Latency: with start accepted at cycle T:
  - issues occur at T+1..T+len;
  - fma_en is high at T+2..T+len+1;
  - res_valid rises at T+len+2 (for len=0, at T+1).
- fma_en is 0 and mem_rd is 0 outside the cycles defined above. fma_a and fma_b are 0 when fma_en=0.
- DONE:
  - res_valid=1; res_data is held stable until res_valid&&res_ready.
  - On that handshake, go to IDLE. start is ignored in the same cycle and is accepted from IDLE on the following cycle.
- Ignored inputs:
  - start while busy.
  - res_ready while res_valid=0.
  - Parameter inputs are sampled only on the accepting cycle; later changes have no effect on the running job.
- abort:
  - In RUN: go to IDLE next cycle. mem_rd and fma_en are forced to 0 in the abort cycle and after, and no result is produced.
  - In DONE: drops the result and goes to IDLE.
  - In IDLE: ignored.
  - abort has priority over completion in the same cycle.
- busy = (state≠IDLE).

Test Plan:
- Row dot product: len=4, base_a=0, base_b=16, stride_b=1, seed=0, A=[1,2,3,4], B=[5,6,7,8] -> res_data=70, res_valid at T+6, fma_en high exactly 4 cycles, fma_update_acc high on the first only.
- Column access with seed: len=3, stride_b=4, base_b=2, seed=10, A=[1,1,1], B[2]=3, B[6]=-4, B[10]=5 -> addresses 2,6,10; res_data=14.
- Zero length and back-pressure: len=0, seed=-7 -> res_valid at T+1 with res_data=-7 and no mem_rd/fma_en. Hold res_ready=0 for 5 cycles -> output stable; a start pulse during DONE is ignored.
- Address wrap and overflow: ADDR_W=8, base_a=254, len=4 -> A addresses 254,255,0,1. Operands 0x7FFFFFFF×2 accumulate with WIDTH-bit truncation, matching the software model.
- Abort and reset mid-job: abort at the second execute cycle of a len=8 job -> IDLE next cycle, no res_valid, and a new job started afterwards gives the correct sum. rst asserted during RUN -> all outputs 0 the next cycle.
- Back-to-back jobs: handshake result 1, then start on the next cycle -> second result correct; fma_update_acc=1 on its first element, so there is no carry-over from job 1.

Source files
------------

// File: rtl/fma_dot_sequencer_if.sv
// Bundles the job, operand-memory, FMA and result signals of the dot-product sequencer.
// The sequencer connects to the master modport; the environment connects to the slave modport.
interface fma_dot_sequencer_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] stride_b;
  logic [ADDR_W-1:0] len;
  logic [WIDTH-1:0]  seed;
  logic              abort;
  logic              busy;
  logic [ADDR_W-1:0] mem_a_addr;
  logic [ADDR_W-1:0] mem_b_addr;
  logic              mem_rd;
  logic [WIDTH-1:0]  mem_a_data;
  logic [WIDTH-1:0]  mem_b_data;
  logic [WIDTH-1:0]  fma_a;
  logic [WIDTH-1:0]  fma_b;
  logic [WIDTH-1:0]  fma_seed;
  logic              fma_update_acc;
  logic              fma_en;
  logic [WIDTH-1:0]  fma_acc;
  logic              res_valid;
  logic [WIDTH-1:0]  res_data;
  logic              res_ready;

  modport master (
    input  start, base_a, base_b, stride_b, len, seed, abort,
    input  mem_a_data, mem_b_data, fma_acc, res_ready,
    output busy, mem_a_addr, mem_b_addr, mem_rd,
    output fma_a, fma_b, fma_seed, fma_update_acc, fma_en,
    output res_valid, res_data
  );

  modport slave (
    output start, base_a, base_b, stride_b, len, seed, abort,
    output mem_a_data, mem_b_data, fma_acc, res_ready,
    input  busy, mem_a_addr, mem_b_addr, mem_rd,
    input  fma_a, fma_b, fma_seed, fma_update_acc, fma_en,
    input  res_valid, res_data
  );
endinterface

// File: rtl/fma_dot_sequencer.sv
// Drives one FMA through a dot product: issues operand reads, enables the FMA one cycle
// later per element, and returns the final accumulator through a valid/ready port.
module fma_dot_sequencer #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fma_dot_sequencer_if.master  bus
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] a_addr, b_addr, stride, len_q, cnt;
  logic [WIDTH-1:0]  seed_q, res_q;
  logic              exec_v, exec_first, exec_last;
  logic              issue, fire;

  // Issue runs while elements remain; execute trails issue by the memory latency.
  always_comb begin
    issue = (state == RUN) && (cnt != len_q) && !bus.abort;
    fire  = (state == RUN) && exec_v && !bus.abort;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.len == '0) ? DONE : RUN;
      RUN: begin
        if (bus.abort)                state_nxt = IDLE;
        else if (fire && exec_last)   state_nxt = DONE;
      end
      DONE: if (bus.abort || bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy           = (state != IDLE);
    bus.mem_rd         = issue;
    bus.mem_a_addr     = a_addr;
    bus.mem_b_addr     = b_addr;
    bus.fma_en         = fire;
    bus.fma_a          = fire ? bus.mem_a_data : '0;
    bus.fma_b          = fire ? bus.mem_b_data : '0;
    bus.fma_update_acc = fire && exec_first;
    bus.fma_seed       = seed_q;
    bus.res_valid      = (state == DONE);
    bus.res_data       = res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_addr     <= '0;
      b_addr     <= '0;
      stride     <= '0;
      len_q      <= '0;
      cnt        <= '0;
      seed_q     <= '0;
      res_q      <= '0;
      exec_v     <= 1'b0;
      exec_first <= 1'b0;
      exec_last  <= 1'b0;
    end else begin
      exec_v     <= issue;
      exec_first <= issue && (cnt == '0);
      exec_last  <= issue && (cnt == len_q - ONE);
      if (state == IDLE && bus.start) begin
        a_addr <= bus.base_a;
        b_addr <= bus.base_b;
        stride <= bus.stride_b;
        len_q  <= bus.len;
        seed_q <= bus.seed;
        cnt    <= '0;
        if (bus.len == '0) res_q <= bus.seed;
      end else if (issue) begin
        a_addr <= a_addr + ONE;
        b_addr <= b_addr + stride;
        cnt    <= cnt + ONE;
      end
      if (fire && exec_last) res_q <= bus.fma_acc;
    end
  end

endmodule
